split_sort_p2: RTL and testbench
================================

# split_sort_p2

Producer-side counterpart of the P2 merge sorter. It reads an 8-entry unsorted byte array through a K-indexed memory port and writes two 4-entry arrays, P and Q, each sorted ascending by insertion. P holds source entries 0–3 and Q holds entries 4–7, which is the input format `merge_sort_P2` expects. It uses the same Start/Ack handshake and one-hot state style as the sorter, so both blocks can be sequenced by one bench or controller.

## Interface

Parameters: none. Widths are fixed: 8-bit data and 4-bit indices.

- Clk  input  1  rising-edge clock; the block's single clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  begin a run; sampled only in INI
- Ack  input  1  acknowledge completion; sampled only in DONE
- Rs_of_K  input  8  source data R[K]; combinational read, valid within the same cycle as K
- K  output  4  source read index
- Ps_of_I  output  8  write data for P[I]
- I  output  4  P write index
- Ps_of_I_Write  output  1  P write strobe; the memory captures on the next rising edge
- Qs_of_J  output  8  write data for Q[J]
- J  output  4  Q write index
- Qs_of_J_Write  output  1  Q write strobe

## Operation

- The state register is named `state`, 5-bit one-hot: INI=00001, LDP=00010, LDQ=00100, WRQ=01000, DONE=10000. DONE must be bit 4.
- Internal storage: two 4×8 register buffers, pbuf and qbuf.
- **INI:** clear K, I, J to 0 every cycle. On Start=1, go to LDP.
- **LDP (4 cycles, K=0..3):**
  - Insert x=Rs_of_K into pbuf, which currently holds n=K[1:0] valid entries.
  - pos = count of valid entries ≤ x. Entries below pos stay in place, slot pos takes x, entries from pos upward shift up by one.
  - Increment K. After the K=3 cycle, go to LDQ.
- **LDQ (4 cycles, K=4..7):**
  - Insert Rs_of_K into qbuf using the same rule, with n=K[1:0].
  - In parallel, write P: Ps_of_I_Write=1, Ps_of_I=pbuf[I], I increments 0..3.
  - After the K=7 cycle, go to WRQ.
- **WRQ (4 cycles):** Qs_of_J_Write=1, Qs_of_J=qbuf[J], J increments 0..3. After J=3, go to DONE.
- **DONE:** all strobes are 0. Stay until Ack=1, then go to INI.
- Compares are 8-bit unsigned. Equal values are inserted after existing equal entries (stable insertion).
- Write strobes decode directly from `state` (Moore outputs). Ps_of_I and Qs_of_J are pure buffer reads.

## Timing

- **Reset (asynchronous, takes effect immediately):** state=INI; K=I=J=0; Ps_of_I_Write=Qs_of_J_Write=0. pbuf/qbuf contents are don't-care.
- **Latency:** the edge that samples Start moves INI→LDP. DONE is entered exactly 12 clocks later (4 LDP + 4 LDQ + 4 WRQ).
- **Read side:** K must be stable from at least 1 ns after a clock edge, because the source memory has a 1 ns combinational read delay.
- **Write side:** each active strobe cycle writes exactly one P or Q entry. Totals per run: 4 P writes at I=0..3 and 4 Q writes at J=0..3, with no duplicate indices.
- **Index ranges:** K never exceeds 7; I and J never exceed 3. No wrap-around occurs within a run.
- **Start outside INI:** ignored. Start held high through a whole run does not cause a re-trigger until after DONE→INI.
- **Ack outside DONE:** ignored. Ack held high during DONE returns to INI on the next edge. If Start is also high in that INI cycle, a new run begins on the following edge.
- **Reset mid-run (e.g. in LDQ):** strobes deassert at once. The run is abandoned and P/Q contents are partial. The next Start produces a complete, correct run.

## Test plan

- **Out-of-order:** R={17,12,11,10,16,15,14,13} → P={10,11,12,17}, Q={13,14,15,16}. DONE reached exactly 12 clocks after Start is sampled. The output then passes through `merge_sort_P2` as R={10..17}.
- **Fully descending:** R={27,26,25,24,23,22,21,20} → P={24,25,26,27}, Q={20,21,22,23}. This exercises the pos=0 shift on every insert.
- **All identical:** all eight entries 44 → P and Q all 44. Exactly 8 write strobes total, with I and J each covering 0..3 once.
- **Duplicates mixed:** R={55,50,55,50,50,55,50,55} → P={50,50,55,55}, Q={50,50,55,55}.
- **Reset mid-run:** assert Reset during the 2nd LDQ cycle.
  - Required: strobes drop within the same cycle and state=INI.
  - Then Start with the first test's array → correct P/Q and a 12-clock latency.
- **Handshake:**
  - Start pulsed during WRQ → no effect.
  - Ack held for 3 cycles in DONE → a single DONE→INI transition.
  - Back-to-back runs with no idle gap → correct results both times.

Source files
------------

// File: rtl/split_sort_p2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// split_sort_p2 : reads R[0..7], insertion-sorts halves into P (0-3) and Q (4-7)
// Revision 1.0
// ============================================================================
module split_sort_p2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic [7:0] Rs_of_K,
  output logic [3:0] K,
  output logic [7:0] Ps_of_I,
  output logic [3:0] I,
  output logic       Ps_of_I_Write,
  output logic [7:0] Qs_of_J,
  output logic [3:0] J,
  output logic       Qs_of_J_Write
);

  typedef enum logic [4:0] {
    INI  = 5'b00001,
    LDP  = 5'b00010,
    LDQ  = 5'b00100,
    WRQ  = 5'b01000,
    DONE = 5'b10000
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0][7:0] pbuf;
  logic [3:0][7:0] qbuf;

  // Stable insert: x lands after every valid entry that is <= x.
  function automatic logic [3:0][7:0] insert_sorted(input logic [3:0][7:0] cur,
                                                    input logic [1:0]       n,
                                                    input logic [7:0]       x);
    logic [3:0][7:0] res;
    logic [2:0]      pos;
    pos = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if ((3'(i) < {1'b0, n}) && (cur[i] <= x)) pos = pos + 3'd1;
    end
    res[0] = (pos == 3'd0) ? x : cur[0];
    for (int i = 1; i < 4; i++) begin
      if (3'(i) < pos)       res[i] = cur[i];
      else if (3'(i) == pos) res[i] = x;
      else                   res[i] = cur[i-1];
    end
    return res;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= INI;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    Ps_of_I_Write = 1'b0;
    Qs_of_J_Write = 1'b0;
    case (state)
      INI:  if (Start) state_nxt = LDP;
      LDP:  if (K[1:0] == 2'd3) state_nxt = LDQ;
      LDQ: begin
        Ps_of_I_Write = 1'b1;
        if (K[1:0] == 2'd3) state_nxt = WRQ;
      end
      WRQ: begin
        Qs_of_J_Write = 1'b1;
        if (J == 4'd3) state_nxt = DONE;
      end
      DONE: if (Ack) state_nxt = INI;
      default: state_nxt = INI;
    endcase
  end

  // Indices saturate at their last value so none ever leaves its range.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      K <= 4'd0;
      I <= 4'd0;
      J <= 4'd0;
    end else begin
      case (state)
        INI: begin
          K <= 4'd0;
          I <= 4'd0;
          J <= 4'd0;
        end
        LDP: K <= K + 4'd1;
        LDQ: begin
          if (K != 4'd7) K <= K + 4'd1;
          if (I != 4'd3) I <= I + 4'd1;
        end
        WRQ: if (J != 4'd3) J <= J + 4'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (state == LDP) pbuf <= insert_sorted(pbuf, K[1:0], Rs_of_K);
    if (state == LDQ) qbuf <= insert_sorted(qbuf, K[1:0], Rs_of_K);
  end

  assign Ps_of_I = pbuf[I[1:0]];
  assign Qs_of_J = qbuf[J[1:0]];

endmodule
`default_nettype wire

// File: tb/tb_split_sort_p2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_split_sort_p2 : randomized + directed bench against a sort-based model
// Revision 1.0
// ============================================================================
module tb_split_sort_p2;

  logic       Clk = 1'b0;
  logic       Reset, Start, Ack;
  logic [7:0] Rs_of_K;
  logic [3:0] K, I, J;
  logic [7:0] Ps_of_I, Qs_of_J;
  logic       Ps_of_I_Write, Qs_of_J_Write;

  split_sort_p2 dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Rs_of_K(Rs_of_K),
    .K(K), .Ps_of_I(Ps_of_I), .I(I), .Ps_of_I_Write(Ps_of_I_Write),
    .Qs_of_J(Qs_of_J), .J(J), .Qs_of_J_Write(Qs_of_J_Write)
  );

  always #5 Clk = ~Clk;

  logic [7:0] src [8];
  assign Rs_of_K = src[K[2:0]];

  int n_tests = 0;
  int n_fail  = 0;

  // Write-side memories; cleared whenever the DUT sits in INI.
  logic [7:0] p_cap [4];
  logic [7:0] q_cap [4];
  logic [3:0] p_mask = 4'h0, q_mask = 4'h0;
  int         p_wr = 0, q_wr = 0;
  logic       idx_bad = 1'b0;

  always @(posedge Clk) begin
    if (dut.state == 5'b00001) begin
      p_wr = 0; q_wr = 0; p_mask = 4'h0; q_mask = 4'h0;
    end
    if (Ps_of_I_Write) begin
      if (I > 4'd3 || p_mask[I[1:0]]) idx_bad = 1'b1;
      else begin p_cap[I[1:0]] = Ps_of_I; p_mask[I[1:0]] = 1'b1; end
      p_wr++;
    end
    if (Qs_of_J_Write) begin
      if (J > 4'd3 || q_mask[J[1:0]]) idx_bad = 1'b1;
      else begin q_cap[J[1:0]] = Qs_of_J; q_mask[J[1:0]] = 1'b1; end
      q_wr++;
    end
    if (K > 4'd7) idx_bad = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the four source bytes starting at base, sorted ascending.
  function automatic logic [31:0] sorted4(input int base);
    logic [7:0] a [4];
    logic [7:0] t;
    for (int i = 0; i < 4; i++) a[i] = src[base + i];
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 3 - p; i++)
        if (a[i] > a[i+1]) begin t = a[i]; a[i] = a[i+1]; a[i+1] = t; end
    return {a[3], a[2], a[1], a[0]};
  endfunction

  task automatic load(input logic [63:0] v);
    for (int i = 0; i < 8; i++) src[i] = v[63 - 8*i -: 8];
  endtask

  task automatic launch();
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit wrq_pulse);
    int cyc;
    cyc = 0;
    while (!dut.state[4] && cyc < 20) begin
      @(posedge Clk);
      #1 cyc++;
      if (wrq_pulse) Start = (cyc == 9);
    end
    Start = 1'b0;
    check_eq({tag, ".latency"}, 32'(cyc), 32'd12);
  endtask

  task automatic verify(input string tag);
    check_eq({tag, ".P"}, {p_cap[3], p_cap[2], p_cap[1], p_cap[0]}, sorted4(0));
    check_eq({tag, ".Q"}, {q_cap[3], q_cap[2], q_cap[1], q_cap[0]}, sorted4(4));
    check_eq({tag, ".writes"}, {8'(p_wr), 8'(q_wr), 4'(p_mask), 4'(q_mask), 7'd0, idx_bad},
             {8'd4, 8'd4, 4'hF, 4'hF, 7'd0, 1'b0});
  endtask

  task automatic ack_done(input string tag);
    Ack = 1'b1;
    @(posedge Clk);
    #1 Ack = 1'b0;
    check_eq({tag, ".ini"}, 32'(dut.state), 32'h01);
  endtask

  task automatic full_run(input string tag, input logic [63:0] v);
    load(v);
    launch();
    wait_done(tag, 1'b0);
    verify(tag);
    ack_done(tag);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0;
    for (int i = 0; i < 8; i++) src[i] = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    check_eq("reset.state", 32'(dut.state), 32'h01);
    check_eq("reset.idx", {20'd0, K, I, J}, 32'd0);
    check_eq("reset.strobes", {30'd0, Ps_of_I_Write, Qs_of_J_Write}, 32'd0);
    @(negedge Clk) Reset = 1'b0;

    full_run("ooo",  {8'd17, 8'd12, 8'd11, 8'd10, 8'd16, 8'd15, 8'd14, 8'd13});
    check_eq("ooo.P_lit", {p_cap[3], p_cap[2], p_cap[1], p_cap[0]}, {8'd17, 8'd12, 8'd11, 8'd10});
    full_run("desc", {8'd27, 8'd26, 8'd25, 8'd24, 8'd23, 8'd22, 8'd21, 8'd20});
    full_run("same", {8{8'd44}});
    full_run("dups", {8'd55, 8'd50, 8'd55, 8'd50, 8'd50, 8'd55, 8'd50, 8'd55});
    full_run("edge", {8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd255, 8'd128});

    // Abort in the second LDQ cycle.
    load({8'd99, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7});
    launch();
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b1;
    #1;
    check_eq("midrst.strobes", {30'd0, Ps_of_I_Write, Qs_of_J_Write}, 32'd0);
    check_eq("midrst.state", 32'(dut.state), 32'h01);
    @(negedge Clk) Reset = 1'b0;
    full_run("after_rst", {8'd17, 8'd12, 8'd11, 8'd10, 8'd16, 8'd15, 8'd14, 8'd13});

    // Start pulsed in WRQ, DONE held without Ack, then Ack held 3 cycles.
    load({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2});
    launch();
    wait_done("wrq_start", 1'b1);
    verify("wrq_start");
    repeat (2) @(posedge Clk);
    #1 check_eq("done.hold", 32'(dut.state), 32'h10);
    Ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk);
      #1 check_eq($sformatf("ack_hold.%0d", c), 32'(dut.state), 32'h01);
    end
    Ack = 1'b0;

    // Back-to-back: Ack and Start together, no idle gap.
    load({8'd31, 8'd30, 8'd33, 8'd32, 8'd35, 8'd34, 8'd37, 8'd36});
    launch();
    wait_done("b2b_a", 1'b0);
    verify("b2b_a");
    load({8'd70, 8'd60, 8'd50, 8'd40, 8'd41, 8'd51, 8'd61, 8'd71});
    Ack = 1'b1; Start = 1'b1;
    @(posedge Clk);
    #1 check_eq("b2b.ini", 32'(dut.state), 32'h01);
    @(posedge Clk);
    #1 Ack = 1'b0; Start = 1'b0;
    check_eq("b2b.ldp", 32'(dut.state), 32'h02);
    wait_done("b2b_b", 1'b0);
    verify("b2b_b");
    ack_done("b2b_b");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++)
        src[i] = (r % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(250, 253));
      launch();
      wait_done($sformatf("rnd%0d", r), 1'b0);
      verify($sformatf("rnd%0d", r));
      ack_done($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
